// File: rtl/bnnroll_stream_if.sv
// bnnroll_stream_if: sample-in / prediction-out handshake bundle for bnnroll_stream.
// Carries the winning popcount as well when BNNROLL_SCORE_EN is defined.
interface bnnroll_stream_if #(
    parameter int FEAT_W = 64,
    parameter int PRED_W = 4
`ifdef BNNROLL_SCORE_EN
    , parameter int SCORE_W = 6
`endif
);
    logic [FEAT_W-1:0] features;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [PRED_W-1:0] prediction;
`ifdef BNNROLL_SCORE_EN
    logic [SCORE_W-1:0] score;
    modport master (output features, in_valid, out_ready, input in_ready, out_valid, prediction, score);
    modport slave  (input features, in_valid, out_ready, output in_ready, out_valid, prediction, score);
`else
    modport master (output features, in_valid, out_ready, input in_ready, out_valid, prediction);
    modport slave  (input features, in_valid, out_ready, output in_ready, out_valid, prediction);
`endif
endinterface

// File: rtl/bnnroll_stream.sv
// bnnroll_stream: handshaked rolled BNN classifier, PAR hidden neurons per cycle then one class per cycle.
// Define BNNROLL_SCORE_EN to also latch and expose the winning popcount.
module bnnroll_stream #(
    parameter int FEAT_CNT   = 16,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 10,
    parameter int PAR        = 1,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
    input logic clk,
    input logic rst,
    bnnroll_stream_if.slave bus
);
    localparam int ACC_W   = FEAT_BITS + $clog2(FEAT_CNT + 1) + 1;
    localparam int SCORE_W = $clog2(HIDDEN_CNT + 1);
    localparam int PRED_W  = $clog2(CLASS_CNT) < 1 ? 1 : $clog2(CLASS_CNT);
    localparam int CW      = $clog2(HIDDEN_CNT + 1);

    typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

    state_t                      r_state, w_next;
    logic [FEAT_BITS*FEAT_CNT-1:0] r_feat;
    logic [HIDDEN_CNT-1:0]       r_hidden, w_hidden;
    logic [CW-1:0]               r_cnt;
    logic [PRED_W-1:0]           r_cls, r_best_idx, r_pred;
    logic [SCORE_W-1:0]          r_best, w_score;
    logic [PAR-1:0]              w_lane;
    logic signed [ACC_W-1:0]     w_acc;
    logic [FEAT_CNT-1:0]         w_row;
    logic [HIDDEN_CNT-1:0]       w_row2;
    logic                        w_last_hid, w_last_cls, w_take;

    // Lane p evaluates neuron r_cnt+p; lanes past the last neuron match no hidden bit and drop out.
    always_comb begin
        w_lane = '0;
        w_acc  = '0;
        w_row  = '0;
        for (int p = 0; p < PAR; p++) begin
            w_row = FEAT_CNT'(W1 >> ((int'(r_cnt) + p) * FEAT_CNT));
            w_acc = '0;
            for (int f = 0; f < FEAT_CNT; f++)
                w_acc = w_row[f] ? w_acc + ACC_W'(r_feat[f*FEAT_BITS +: FEAT_BITS])
                                 : w_acc - ACC_W'(r_feat[f*FEAT_BITS +: FEAT_BITS]);
            w_lane[p] = ~w_acc[ACC_W-1];
        end
        w_hidden = r_hidden;
        for (int h = 0; h < HIDDEN_CNT; h++)
            for (int p = 0; p < PAR; p++)
                if (int'(r_cnt) + p == h) w_hidden[h] = w_lane[p];
    end

    always_comb begin
        w_row2  = HIDDEN_CNT'(W2 >> (int'(r_cls) * HIDDEN_CNT));
        w_score = '0;
        for (int h = 0; h < HIDDEN_CNT; h++)
            w_score = w_score + SCORE_W'(~(r_hidden[h] ^ w_row2[h]));
    end

    assign w_last_hid = int'(r_cnt) + PAR >= HIDDEN_CNT;
    assign w_last_cls = r_cls == PRED_W'(CLASS_CNT - 1);
    assign w_take     = (r_cls == '0) || (w_score > r_best);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.in_valid ? HID : IDLE;
            HID:     w_next = w_last_hid ? OUT : HID;
            OUT:     w_next = w_last_cls ? DONE : OUT;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

`ifdef BNNROLL_SCORE_EN
    logic [SCORE_W-1:0] r_score;
    assign bus.score = r_score;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_feat     <= '0;
            r_hidden   <= '0;
            r_cnt      <= '0;
            r_cls      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_pred     <= '0;
`ifdef BNNROLL_SCORE_EN
            r_score    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_feat   <= bus.features;
                    r_hidden <= '0;
                    r_cnt    <= '0;
                end
                HID: begin
                    r_hidden <= w_hidden;
                    r_cnt    <= r_cnt + CW'(PAR);
                    if (w_last_hid) begin
                        r_cls      <= '0;
                        r_best     <= '0;
                        r_best_idx <= '0;
                    end
                end
                OUT: begin
                    if (w_take) begin
                        r_best     <= w_score;
                        r_best_idx <= r_cls;
                    end
                    r_cls <= r_cls + PRED_W'(1);
                    // The final class is compared in the same cycle the result is latched.
                    if (w_last_cls) begin
                        r_pred  <= w_take ? r_cls : r_best_idx;
`ifdef BNNROLL_SCORE_EN
                        r_score <= w_take ? w_score : r_best;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = r_state == IDLE;
    assign bus.out_valid  = r_state == DONE;
    assign bus.prediction = r_pred;
endmodule

// File: doc/bnnroll_stream.md
Name: bnnroll_stream

Overview:
- Parametrised, handshaked successor to the rolled single-hidden-layer BNN classifier.
- Computes the hidden layer PAR neurons per cycle, then scores classes one per cycle with a running argmax.
- Accepts samples on a valid/ready input and returns the class on a valid/ready output.
- Sits between the feature source and the result sink in the bnnroll product designs.

Parameters:
- FEAT_CNT, 16: number of input features.
- FEAT_BITS, 4: unsigned width of each feature.
- HIDDEN_CNT, 40: number of hidden neurons.
- CLASS_CNT, 10: number of output classes; must be ≥2.
- PAR, 1: hidden neurons evaluated per cycle; 1 ≤ PAR ≤ HIDDEN_CNT.
- W1, 0: HIDDEN_CNT*FEAT_CNT bits; bit [h*FEAT_CNT+f] is the weight of feature f into hidden neuron h; 1 means +1, 0 means −1.
- W2, 0: CLASS_CNT*HIDDEN_CNT bits; bit [c*HIDDEN_CNT+h] is the weight of hidden bit h into class c.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- features  in  FEAT_BITS*FEAT_CNT  packed sample; feature f is bits [f*FEAT_BITS +: FEAT_BITS].
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- out_valid  out  1  prediction valid.
- out_ready  in  1  sink accepts the prediction.
- prediction  out  max(1,$clog2(CLASS_CNT))  winning class index.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, in_ready=1, out_valid=0, prediction=0.
  - All accumulators, hidden register and counters are cleared.
- FSM states: IDLE, HID, OUT, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready: register features, clear the hidden register, set the neuron counter to 0, go to HID.
- HID: each cycle evaluates neurons n..n+PAR−1.
  - Accumulator per neuron is signed, width FEAT_BITS+$clog2(FEAT_CNT+1)+1: sum of +feature where the weight is 1, −feature where the weight is 0.
  - Hidden bit = (acc >= 0), so acc=0 gives 1.
  - The counter advances by PAR each cycle.
  - On the last step, lanes with index ≥ HIDDEN_CNT are ignored.
  - After ceil(HIDDEN_CNT/PAR) cycles: go to OUT with class counter 0, best score 0, best index 0.
- OUT: each cycle scores class c.
  - score = popcount(XNOR(hidden, W2 row c)), width $clog2(HIDDEN_CNT+1).
  - Update the best only if score > best score, strictly; ties keep the lower index.
  - Class 0 is always loaded as the initial best.
  - After CLASS_CNT cycles: latch prediction, go to DONE.
- DONE:
  - out_valid=1; prediction is stable until handshake.
  - On out_ready: go to IDLE and drop out_valid.
  - in_ready is 0, so a new sample cannot be accepted in the same cycle; one-cycle bubble.
- Latency: out_valid rises exactly ceil(HIDDEN_CNT/PAR)+CLASS_CNT cycles after the accept edge.
- in_ready=0 in HID, OUT and DONE; in_valid is ignored there and features may change freely.
- prediction holds its last value across IDLE; it is only meaningful while out_valid=1.
- Reset mid-operation: the in-flight sample is discarded; no out_valid is produced for it.

Optional Feature:
- Macro BNNROLL_SCORE_EN.
- When defined: adds output port score (width $clog2(HIDDEN_CNT+1)) carrying the winning popcount, latched with prediction and reset to 0.
- When undefined: port and register are absent; behaviour is otherwise identical.

Test Plan:
- FEAT_CNT=2, FEAT_BITS=4, HIDDEN_CNT=4, CLASS_CNT=3, PAR=2, W1=all 1s, W2 rows c0=0000, c1=1111, c2=0011; features={3,5}.
  - Expect all hidden=1, scores 0/4/2, prediction=1 (score=4 with BNNROLL_SCORE_EN).
  - out_valid rises 5 cycles after accept.
- Same config, c0=1111, c1=1111 → tie; prediction=0.
- W1=all 0s: features={1,0} → hidden=0000, c0=0000 scores 4, prediction=0. features={0,0} → acc=0 → hidden=1111, prediction=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Expect prediction stable, in_ready=0, and a new in_valid ignored.
  - After out_ready=1: in_ready=1 on the next cycle.
- PAR=3 with HIDDEN_CNT=4: HID lasts 2 cycles; results match PAR=1 on 1000 random samples against a reference model.
- Drive rst=0 during HID. Expect immediate out_valid=0, in_ready=1, prediction=0. After release, a new sample completes normally.
